tw_cmd_sequencer: RTL

- Command-queue front end that sits directly upstream of the 3-wire serial master and drives its start/mode/address/write-data inputs.
- Buffers host register transactions (write or read) in a command FIFO and issues them one at a time.
- Waits for each transfer to finish, then pushes read results into a response FIFO.
- Decouples a bursty host (UART/bus bridge) from the slow serial link.

---
 rtl/tw_cmd_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tw_cmd_sequencer.sv
// Command-queue front end for the 3-wire serial master: buffers host transactions,
// issues them one at a time, and queues read results. Optional macro: TW_CMD_SEQUENCER_TIMEOUT_EN.
module tw_cmd_sequencer #(
   parameter int ADDR_BITS = 9,
   parameter int DATA_BITS = 16,
   parameter int CMD_AW    = 3,
   parameter int RSP_AW    = 2
`ifdef TW_CMD_SEQUENCER_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 1023
`endif
) (
   input  logic                 in_clk,
   input  logic                 in_rst,
   input  logic                 in_cmd_valid,
   output logic                 out_cmd_ready,
   input  logic                 in_cmd_wr,
   input  logic [ADDR_BITS-1:0] in_cmd_addr,
   input  logic [DATA_BITS-1:0] in_cmd_data,
   output logic                 out_rsp_valid,
   input  logic                 in_rsp_ready,
   output logic [ADDR_BITS-1:0] out_rsp_addr,
   output logic [DATA_BITS-1:0] out_rsp_data,
   output logic                 out_tw_start,
   output logic                 out_tw_mode_wr,
   output logic [ADDR_BITS-1:0] out_tw_addr,
   output logic [DATA_BITS-1:0] out_tw_wr_data,
   input  logic [DATA_BITS-1:0] in_tw_rd_data,
   input  logic                 in_tw_io_in_progress,
   output logic                 out_busy,
   output logic [CMD_AW:0]      out_cmd_level
`ifdef TW_CMD_SEQUENCER_TIMEOUT_EN
   , output logic               out_err
`endif
);

   localparam int CW = 1 + ADDR_BITS + DATA_BITS;
   localparam int RW = ADDR_BITS + DATA_BITS;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE     = 3'd1;
   localparam logic [2:0] WAIT_BUSY = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] CAPTURE   = 3'd4;

   logic [2:0] state, state_nx;

   // command FIFO
   logic [CW-1:0]   cmd_mem [2**CMD_AW];
   logic [CMD_AW:0] cmd_wp, cmd_rp;
   logic            cmd_full, cmd_empty, cmd_push, cmd_pop;
   logic [CW-1:0]   cmd_head;

   assign out_cmd_level = cmd_wp - cmd_rp;
   assign cmd_full      = out_cmd_level[CMD_AW];
   assign cmd_empty     = (cmd_wp == cmd_rp);
   assign out_cmd_ready = ~cmd_full;
   assign cmd_push      = in_cmd_valid & ~cmd_full;
   assign cmd_head      = cmd_mem[cmd_rp[CMD_AW-1:0]];

   // response FIFO
   logic [RW-1:0]   rsp_mem [2**RSP_AW];
   logic [RSP_AW:0] rsp_wp, rsp_rp, rsp_lvl;
   logic            rsp_full, rsp_push, rsp_pop;

   assign rsp_lvl       = rsp_wp - rsp_rp;
   assign rsp_full      = rsp_lvl[RSP_AW];
   assign out_rsp_valid = (rsp_wp != rsp_rp);
   assign rsp_pop       = out_rsp_valid & in_rsp_ready;
   assign rsp_push      = (state == CAPTURE);
   assign {out_rsp_addr, out_rsp_data} = rsp_mem[rsp_rp[RSP_AW-1:0]];

   // a read needs a guaranteed response slot before it may leave the queue
   assign cmd_pop = (state == IDLE) & ~cmd_empty & ~in_tw_io_in_progress &
                    (cmd_head[CW-1] | ~rsp_full);

   assign out_tw_start = (state == ISSUE);
   assign out_busy     = ~((state == IDLE) & cmd_empty);

   always_ff @(posedge in_clk) begin
      if (cmd_push) cmd_mem[cmd_wp[CMD_AW-1:0]] <= {in_cmd_wr, in_cmd_addr, in_cmd_data};
      if (rsp_push) rsp_mem[rsp_wp[RSP_AW-1:0]] <= {out_tw_addr, in_tw_rd_data};
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         cmd_wp <= '0;
         cmd_rp <= '0;
         rsp_wp <= '0;
         rsp_rp <= '0;
      end else begin
         if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
         if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
         if (rsp_push) rsp_wp <= rsp_wp + 1'b1;
         if (rsp_pop)  rsp_rp <= rsp_rp + 1'b1;
      end
   end

`ifdef TW_CMD_SEQUENCER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;
   // fires on the cycle the count would reach TIMEOUT_CYCLES
   assign tmo_hit = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (cmd_pop) state_nx = ISSUE;
         ISSUE:     state_nx = WAIT_BUSY;
         WAIT_BUSY: if (in_tw_io_in_progress) state_nx = WAIT_DONE;
         WAIT_DONE: if (!in_tw_io_in_progress) state_nx = out_tw_mode_wr ? IDLE : CAPTURE;
         CAPTURE:   state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
`ifdef TW_CMD_SEQUENCER_TIMEOUT_EN
      if (tmo_hit) state_nx = IDLE;
`endif
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state          <= IDLE;
         out_tw_mode_wr <= 1'b0;
         out_tw_addr    <= '0;
         out_tw_wr_data <= '0;
      end else begin
         state <= state_nx;
         if (cmd_pop) {out_tw_mode_wr, out_tw_addr, out_tw_wr_data} <= cmd_head;
      end
   end

`ifdef TW_CMD_SEQUENCER_TIMEOUT_EN
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         tmo_cnt <= '0;
         out_err <= 1'b0;
      end else begin
         if (state_nx != state) tmo_cnt <= '0;
         else if ((state == WAIT_BUSY) || (state == WAIT_DONE)) tmo_cnt <= tmo_cnt + 1'b1;
         if (tmo_hit) out_err <= 1'b1;
      end
   end
`endif

endmodule
